ec_fwd_conv_digit: RTL and testbench



---
 rtl/ec_fwd_conv_digit.sv | 171 +++++++++++++++++
 tb/tb_ec_fwd_conv_digit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ec_fwd_conv_digit.sv
// Forward converter for one RNS digit lane.
// Reduces a sign-magnitude 64-bit operand modulo MODULUS via a 4-stage Horner
// pipeline (one 16-bit word per stage), applies the sign in a fifth stage, and
// writes the result to the downstream digit FIFO through a registered guard.
// Latency: operand sampled at edge N shows datavalid_out high after edge N+5.

module ec_fwd_conv_digit #(
  parameter int unsigned MODULUS = 262103,
  parameter int unsigned RW      = 18
) (
  input  logic          s_clk,
  input  logic          rst_n,
  input  logic          datavalid_in,
  input  logic          binval_sign,
  input  logic [15:0]   binval_1_,
  input  logic [15:0]   binval_2_,
  input  logic [15:0]   binval_3_,
  input  logic [15:0]   binval_4_,
  input  logic          fifo_wr_full,
  output logic [RW-1:0] residue_out,
  output logic          datavalid_out,
  output logic          overflow_err
);

  // r < M < 2^RW, so r*2^16 + w fits in RW+16 bits (34 for the default lane).
  localparam int unsigned VW = RW + 16;
  localparam logic [VW-1:0] ModW = VW'(MODULUS);
  // Truncates to 0 for M = 2^RW; the RW-bit subtraction M - r still wraps correctly.
  localparam logic [RW-1:0] ModR = RW'(MODULUS);

  // One Horner step: (r*2^16 + w) mod M using a restoring subtract ladder.
  // Since r < M the input is below M*2^16, so 16 conditional subtractions of
  // M*2^k (k = 15..0) leave a value below M.
  function automatic logic [RW-1:0] horner_step(input logic [RW-1:0] r, input logic [15:0] w);
    logic [VW-1:0] v;
    v = {r, w};
    for (int k = 15; k >= 0; k--) begin
      if (v >= (ModW << k)) begin
        v = v - (ModW << k);
      end
    end
    return v[RW-1:0];
  endfunction

  // Stage registers; each stage keeps the words it has not consumed yet.
  logic          s1_valid_q, s1_sign_q;
  logic [RW-1:0] s1_r_q;
  logic [15:0]   s1_w3_q, s1_w2_q, s1_w1_q;

  logic          s2_valid_q, s2_sign_q;
  logic [RW-1:0] s2_r_q;
  logic [15:0]   s2_w2_q, s2_w1_q;

  logic          s3_valid_q, s3_sign_q;
  logic [RW-1:0] s3_r_q;
  logic [15:0]   s3_w1_q;

  logic          s4_valid_q, s4_sign_q;
  logic [RW-1:0] s4_r_q;

  logic          s5_valid_q;
  logic [RW-1:0] s5_res_q, s5_res_d;

  logic          out_valid_q, ovf_q;
  logic [RW-1:0] out_res_q;

  // S1: reduce the most-significant word and capture the rest of the operand.
  always_ff @(posedge s_clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_r_q     <= '0;
      s1_w3_q    <= '0;
      s1_w2_q    <= '0;
      s1_w1_q    <= '0;
    end else begin
      s1_valid_q <= datavalid_in;
      s1_sign_q  <= binval_sign;
      s1_r_q     <= horner_step('0, binval_4_);
      s1_w3_q    <= binval_3_;
      s1_w2_q    <= binval_2_;
      s1_w1_q    <= binval_1_;
    end
  end

  // S2: fold in word 3.
  always_ff @(posedge s_clk) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_r_q     <= '0;
      s2_w2_q    <= '0;
      s2_w1_q    <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_r_q     <= horner_step(s1_r_q, s1_w3_q);
      s2_w2_q    <= s1_w2_q;
      s2_w1_q    <= s1_w1_q;
    end
  end

  // S3: fold in word 2.
  always_ff @(posedge s_clk) begin
    if (!rst_n) begin
      s3_valid_q <= 1'b0;
      s3_sign_q  <= 1'b0;
      s3_r_q     <= '0;
      s3_w1_q    <= '0;
    end else begin
      s3_valid_q <= s2_valid_q;
      s3_sign_q  <= s2_sign_q;
      s3_r_q     <= horner_step(s2_r_q, s2_w2_q);
      s3_w1_q    <= s2_w1_q;
    end
  end

  // S4: fold in the least-significant word; magnitude residue is complete.
  always_ff @(posedge s_clk) begin
    if (!rst_n) begin
      s4_valid_q <= 1'b0;
      s4_sign_q  <= 1'b0;
      s4_r_q     <= '0;
    end else begin
      s4_valid_q <= s3_valid_q;
      s4_sign_q  <= s3_sign_q;
      s4_r_q     <= horner_step(s3_r_q, s3_w1_q);
    end
  end

  // Sign stage: negate modulo M; a negative zero stays 0.
  always_comb begin
    s5_res_d = s4_r_q;
    if (s4_sign_q && (s4_r_q != '0)) begin
      s5_res_d = ModR - s4_r_q;
    end
  end

  // S5: hold the signed residue for the FIFO guard.
  always_ff @(posedge s_clk) begin
    if (!rst_n) begin
      s5_valid_q <= 1'b0;
      s5_res_q   <= '0;
    end else begin
      s5_valid_q <= s4_valid_q;
      s5_res_q   <= s5_res_d;
    end
  end

  // FIFO guard: write when there is room, otherwise drop and flag sticky overflow.
  always_ff @(posedge s_clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= s5_valid_q && !fifo_wr_full;
      if (s5_valid_q && !fifo_wr_full) begin
        out_res_q <= s5_res_q;
      end
      if (s5_valid_q && fifo_wr_full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign residue_out   = out_res_q;
  assign datavalid_out = out_valid_q;
  assign overflow_err  = ovf_q;

endmodule

// File: tb/tb_ec_fwd_conv_digit.sv
// Directed bench for ec_fwd_conv_digit: three lanes (M = 65536, 262103, 78125)
// share one stimulus bus; each task checks the lane it targets.

module tb_ec_fwd_conv_digit;

  logic        s_clk = 1'b0;
  logic        rst_n;
  logic        dv_in;
  logic        sign;
  logic [63:0] x;
  logic        full;

  logic [15:0] res_p2;
  logic        dv_p2, ovf_p2;
  logic [17:0] res_big;
  logic        dv_big, ovf_big;
  logic [16:0] res_bb;
  logic        dv_bb, ovf_bb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 s_clk = ~s_clk;

  ec_fwd_conv_digit #(.MODULUS(65536), .RW(16)) u_p2 (
    .s_clk(s_clk), .rst_n(rst_n), .datavalid_in(dv_in), .binval_sign(sign),
    .binval_1_(x[15:0]), .binval_2_(x[31:16]), .binval_3_(x[47:32]), .binval_4_(x[63:48]),
    .fifo_wr_full(full), .residue_out(res_p2), .datavalid_out(dv_p2), .overflow_err(ovf_p2)
  );

  ec_fwd_conv_digit #(.MODULUS(262103), .RW(18)) u_big (
    .s_clk(s_clk), .rst_n(rst_n), .datavalid_in(dv_in), .binval_sign(sign),
    .binval_1_(x[15:0]), .binval_2_(x[31:16]), .binval_3_(x[47:32]), .binval_4_(x[63:48]),
    .fifo_wr_full(full), .residue_out(res_big), .datavalid_out(dv_big), .overflow_err(ovf_big)
  );

  ec_fwd_conv_digit #(.MODULUS(78125), .RW(17)) u_bb (
    .s_clk(s_clk), .rst_n(rst_n), .datavalid_in(dv_in), .binval_sign(sign),
    .binval_1_(x[15:0]), .binval_2_(x[31:16]), .binval_3_(x[47:32]), .binval_4_(x[63:48]),
    .fifo_wr_full(full), .residue_out(res_bb), .datavalid_out(dv_bb), .overflow_err(ovf_bb)
  );

  // Reference: plain 64-bit modulo, negated when signed and nonzero.
  function automatic logic [63:0] model(input logic [63:0] xv, input logic s,
                                        input logic [63:0] m);
    logic [63:0] r;
    r = xv % m;
    if (s && r != 64'd0) r = m - r;
    return r;
  endfunction

  task automatic step();
    @(posedge s_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [63:0] val);
    dv_in = v;
    sign  = s;
    x     = val;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    full  = 1'b0;
    drive(1'b0, 1'b0, 64'd0);
    repeat (3) step();
    n_checks++;
    if ({dv_p2, ovf_p2, res_p2} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_p2: got %h expected 0", {dv_p2, ovf_p2, res_p2});
    end
    n_checks++;
    if ({dv_big, ovf_big, res_big} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_big: got %h expected 0", {dv_big, ovf_big, res_big});
    end
    n_checks++;
    if ({dv_bb, ovf_bb, res_bb} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_bb: got %h expected 0", {dv_bb, ovf_bb, res_bb});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      n_checks++;
      if ({dv_p2, ovf_p2, res_p2, dv_big, ovf_big, res_big, dv_bb, ovf_bb, res_bb} !== 57'd0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got %h expected 0", c,
                 {dv_p2, ovf_p2, res_p2, dv_big, ovf_big, res_big, dv_bb, ovf_bb, res_bb});
      end
    end
  endtask

  task automatic test_pow2();
    logic [15:0] expv;
    logic        s;
    for (int t = 0; t < 2; t++) begin
      s    = (t == 0);
      expv = (t == 0) ? 16'h0001 : 16'hFFFF;
      for (int c = 0; c < 8; c++) begin
        drive(c == 0, s, 64'h0000_0009_FFFF_FFFF);
        step();
        n_checks++;
        if (dv_p2 !== (c == 5)) begin
          n_fail++;
          $display("FAIL pow2_s%0d_valid_edge%0d: got %b expected %b", s, c, dv_p2, (c == 5));
        end
        if (c == 5) begin
          n_checks++;
          if (res_p2 !== expv) begin
            n_fail++;
            $display("FAIL pow2_s%0d_value: got %h expected %h", s, res_p2, expv);
          end
        end
      end
    end
  endtask

  task automatic test_big();
    logic [63:0] ox[3];
    logic        os[3];
    logic [17:0] oe[3];
    ox[0] = 64'h0000_0001_0000_0000; os[0] = 1'b0; oe[0] = 18'd147538;
    ox[1] = 64'h0000_0001_0000_0000; os[1] = 1'b1; oe[1] = 18'd114565;
    ox[2] = 64'd0;                   os[2] = 1'b1; oe[2] = 18'd0;
    for (int c = 0; c < 11; c++) begin
      if (c < 3) drive(1'b1, os[c], ox[c]);
      else       drive(1'b0, 1'b0, 64'd0);
      step();
      n_checks++;
      if (dv_big !== (c >= 5 && c < 8)) begin
        n_fail++;
        $display("FAIL big_valid_edge%0d: got %b expected %b", c, dv_big, (c >= 5 && c < 8));
      end
      if (c >= 5 && c < 8) begin
        n_checks++;
        if (res_big !== oe[c-5]) begin
          n_fail++;
          $display("FAIL big_value%0d: got %0d expected %0d", c - 5, res_big, oe[c-5]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned hand[8];
    int          k;
    hand = '{1, 78123, 3, 78121, 5, 78119, 7, 78117};
    for (int c = 0; c < 16; c++) begin
      if (c < 8) drive(1'b1, c[0], 64'(c + 1));
      else       drive(1'b0, 1'b0, 64'd0);
      step();
      n_checks++;
      if (dv_bb !== (c >= 5 && c < 13)) begin
        n_fail++;
        $display("FAIL b2b_valid_edge%0d: got %b expected %b", c, dv_bb, (c >= 5 && c < 13));
      end
      if (c >= 5 && c < 13) begin
        k = c - 5;
        n_checks++;
        if (res_bb !== 17'(hand[k])) begin
          n_fail++;
          $display("FAIL b2b_hand%0d: got %0d expected %0d", k, res_bb, hand[k]);
        end
        n_checks++;
        if (64'(res_bb) !== model(64'(k + 1), k[0], 64'd78125)) begin
          n_fail++;
          $display("FAIL b2b_model%0d: got %0d expected %0d", k, res_bb,
                   model(64'(k + 1), k[0], 64'd78125));
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [63:0] ox[5];
    logic        os[5];
    logic        exp_dv;
    int          k;
    ox[0] = 64'hFFFF_FFFF_FFFF_FFFF; os[0] = 1'b0;
    ox[1] = 64'h0123_4567_89AB_CDEF; os[1] = 1'b1;
    ox[2] = 64'h8000_0000_0000_0000; os[2] = 1'b0;
    ox[3] = 64'h0000_0003_FFFD_0001; os[3] = 1'b1;
    ox[4] = 64'hDEAD_BEEF_0BAD_F00D; os[4] = 1'b0;
    for (int c = 0; c < 13; c++) begin
      if (c < 5) drive(1'b1, os[c], ox[c]);
      else       drive(1'b0, 1'b0, 64'd0);
      full = (c == 7);
      step();
      exp_dv = (c == 5) || (c == 6) || (c == 8) || (c == 9);
      n_checks++;
      if (dv_big !== exp_dv) begin
        n_fail++;
        $display("FAIL fifo_valid_edge%0d: got %b expected %b", c, dv_big, exp_dv);
      end
      if (exp_dv) begin
        k = c - 5;
        n_checks++;
        if (64'(res_big) !== model(ox[k], os[k], 64'd262103)) begin
          n_fail++;
          $display("FAIL fifo_value%0d: got %0d expected %0d", k, res_big,
                   model(ox[k], os[k], 64'd262103));
        end
      end
      n_checks++;
      if (ovf_big !== (c >= 7)) begin
        n_fail++;
        $display("FAIL fifo_overflow_edge%0d: got %b expected %b", c, ovf_big, (c >= 7));
      end
    end
    full = 1'b0;
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if (ovf_big !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear: got %b expected 0", ovf_big);
    end
    for (int c = 0; c < 17; c++) begin
      if (c < 4)       drive(1'b1, c[0], 64'h0000_1234_0000_0000 + 64'(c));
      else if (c == 8) drive(1'b1, 1'b1, 64'h0000_0001_0000_0000);
      else             drive(1'b0, 1'b0, 64'd0);
      rst_n = (c != 5);
      full  = (c == 5);
      step();
      n_checks++;
      if (dv_big !== (c == 13)) begin
        n_fail++;
        $display("FAIL midrst_valid_edge%0d: got %b expected %b", c, dv_big, (c == 13));
      end
      n_checks++;
      if (ovf_big !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_overflow_edge%0d: got %b expected 0", c, ovf_big);
      end
      if (c == 5) begin
        n_checks++;
        if (res_big !== 18'd0) begin
          n_fail++;
          $display("FAIL midrst_residue_cleared: got %0d expected 0", res_big);
        end
      end
      if (c == 13) begin
        n_checks++;
        if (res_big !== 18'd114565) begin
          n_fail++;
          $display("FAIL midrst_new_value: got %0d expected 114565", res_big);
        end
      end
    end
    full = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pow2();
    test_big();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
